// File: rtl/hf_seq_encoder.sv
// rtl/hf_seq_encoder.sv - sequential Huffman code generator, one two-minimum merge per cycle
// Defining HF_SEQ_OUT_READY_EN adds an out_ready input that back-pressures the code output.
module hf_seq_encoder #(
  parameter int SYM_NUM = 5,
  parameter int FREQ_W  = 5,
  parameter int CODE_W  = SYM_NUM - 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [FREQ_W-1:0]           in_freq,
  output logic                        in_ready,
`ifdef HF_SEQ_OUT_READY_EN
  input  logic                        out_ready,
`endif
  output logic                        out_valid,
  output logic [$clog2(SYM_NUM)-1:0]  out_sym,
  output logic [CODE_W-1:0]           out_code,
  output logic [$clog2(CODE_W+1)-1:0] out_len
);
  localparam int NODES = 2 * SYM_NUM - 1;
  localparam int SW    = $clog2(SYM_NUM);
  localparam int LW    = $clog2(CODE_W + 1);
  localparam int NW    = $clog2(NODES);
  localparam int WW    = FREQ_W + SW;

  typedef enum logic [1:0] {IDLE, LOAD, MERGE, OUT} state_t;
  state_t state;

  logic [WW-1:0]     weight [NODES];
  logic [NODES-1:0]  active;
  logic [NW-1:0]     group [SYM_NUM];
  logic [CODE_W-1:0] code [SYM_NUM];
  logic [LW-1:0]     len [SYM_NUM];
  logic [SW-1:0]     ld_cnt;
  logic [SW-1:0]     mg_cnt;

  logic [NW-1:0]     min1;
  logic [NW-1:0]     min2;
  logic              found1;
  logic              found2;
  logic [NW-1:0]     new_id;
  logic [NW-1:0]     group_nxt [SYM_NUM];
  logic [CODE_W-1:0] code_nxt [SYM_NUM];
  logic [LW-1:0]     len_nxt [SYM_NUM];
  logic [SW-1:0]     sym_inc;
  logic              out_adv;

`ifdef HF_SEQ_OUT_READY_EN
  assign out_adv = out_ready;
`else
  assign out_adv = 1'b1;
`endif

  assign new_id  = NW'(SYM_NUM) + NW'(mg_cnt);
  assign sym_inc = out_sym + SW'(1);

  // Strict less-than while scanning ids upward keeps the lower id on equal weight.
  always_comb begin
    min1   = '0;
    min2   = '0;
    found1 = 1'b0;
    found2 = 1'b0;
    for (int i = 0; i < NODES; i++) begin
      if (active[i] && (!found1 || weight[i] < weight[min1])) begin
        min1   = NW'(i);
        found1 = 1'b1;
      end
    end
    for (int i = 0; i < NODES; i++) begin
      if (active[i] && (NW'(i) != min1) && (!found2 || weight[i] < weight[min2])) begin
        min2   = NW'(i);
        found2 = 1'b1;
      end
    end
    for (int s = 0; s < SYM_NUM; s++) begin
      group_nxt[s] = group[s];
      code_nxt[s]  = code[s];
      len_nxt[s]   = len[s];
      if (found2 && (group[s] == min1 || group[s] == min2)) begin
        group_nxt[s] = new_id;
        len_nxt[s]   = len[s] + LW'(1);
        if (group[s] == min2) begin
          code_nxt[s] = code[s] | (CODE_W'(1) << len[s]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sym   <= '0;
      out_code  <= '0;
      out_len   <= '0;
      ld_cnt    <= '0;
      mg_cnt    <= '0;
      active    <= '0;
      for (int n = 0; n < NODES; n++) begin
        weight[n] <= '0;
      end
      for (int s = 0; s < SYM_NUM; s++) begin
        group[s] <= '0;
        code[s]  <= '0;
        len[s]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            active    <= NODES'(1);
            weight[0] <= WW'(in_freq);
            group[0]  <= '0;
            code[0]   <= '0;
            len[0]    <= '0;
            ld_cnt    <= SW'(1);
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            active[ld_cnt] <= 1'b1;
            weight[ld_cnt] <= WW'(in_freq);
            group[ld_cnt]  <= NW'(ld_cnt);
            code[ld_cnt]   <= '0;
            len[ld_cnt]    <= '0;
            if (ld_cnt == SW'(SYM_NUM - 1)) begin
              state    <= MERGE;
              in_ready <= 1'b0;
              mg_cnt   <= '0;
            end else begin
              ld_cnt <= ld_cnt + SW'(1);
            end
          end
        end
        MERGE: begin
          active[min1]   <= 1'b0;
          active[min2]   <= 1'b0;
          active[new_id] <= 1'b1;
          weight[new_id] <= weight[min1] + weight[min2];
          for (int s = 0; s < SYM_NUM; s++) begin
            group[s] <= group_nxt[s];
            code[s]  <= code_nxt[s];
            len[s]   <= len_nxt[s];
          end
          // Symbol 0 is presented straight from the final merge result.
          if (mg_cnt == SW'(SYM_NUM - 2)) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_sym   <= '0;
            out_code  <= code_nxt[0];
            out_len   <= len_nxt[0];
          end else begin
            mg_cnt <= mg_cnt + SW'(1);
          end
        end
        OUT: begin
          if (out_adv) begin
            if (out_sym == SW'(SYM_NUM - 1)) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_sym   <= '0;
              out_code  <= '0;
              out_len   <= '0;
            end else begin
              out_sym  <= sym_inc;
              out_code <= code[sym_inc];
              out_len  <= len[sym_inc];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hf_seq_encoder.sv
// tb/tb_hf_seq_encoder.sv - scoreboard bench for hf_seq_encoder (SYM_NUM=5 and SYM_NUM=2)
// With HF_SEQ_OUT_READY_EN defined, out_ready follows the repeating pattern 1,0,0,1.
module tb_hf_seq_encoder;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [4:0] in_freq;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_sym;
  logic [3:0] out_code;
  logic [2:0] out_len;

  logic       in_valid2;
  logic [4:0] in_freq2;
  logic       in_ready2;
  logic       out_valid2;
  logic [0:0] out_sym2;
  logic [0:0] out_code2;
  logic [0:0] out_len2;

  typedef struct {
    int sym;
    int code;
    int len;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  hf_seq_encoder #(.SYM_NUM(5), .FREQ_W(5), .CODE_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_freq   (in_freq),
    .in_ready  (in_ready),
`ifdef HF_SEQ_OUT_READY_EN
    .out_ready (out_ready),
`endif
    .out_valid (out_valid),
    .out_sym   (out_sym),
    .out_code  (out_code),
    .out_len   (out_len)
  );

  hf_seq_encoder #(.SYM_NUM(2), .FREQ_W(5), .CODE_W(1)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_freq   (in_freq2),
    .in_ready  (in_ready2),
`ifdef HF_SEQ_OUT_READY_EN
    .out_ready (1'b1),
`endif
    .out_valid (out_valid2),
    .out_sym   (out_sym2),
    .out_code  (out_code2),
    .out_len   (out_len2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_sym(input int s, input int c, input int l);
    exp_t e;
    e.sym  = s;
    e.code = c;
    e.len  = l;
    sb.push_back(e);
  endtask

  task automatic exp_a();
    exp_sym(0, 'b010, 3); exp_sym(1, 'b011, 3); exp_sym(2, 'b00, 2);
    exp_sym(3, 'b10, 2);  exp_sym(4, 'b11, 2);
  endtask

  task automatic exp_flat();
    exp_sym(0, 'b110, 3); exp_sym(1, 'b111, 3); exp_sym(2, 'b00, 2);
    exp_sym(3, 'b01, 2);  exp_sym(4, 'b10, 2);
  endtask

  // Called at a negedge; returns at the negedge after the capturing edge plus gap cycles.
  task automatic send_sym(input logic [4:0] f, input int gap);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_freq  = f;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((sb.size() != 0 || !in_ready || out_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("idle_timeout", (w < 300) ? 1 : 0, 1);
  endtask

  // Output monitor: compares each accepted symbol against the scoreboard head.
  initial begin
`ifdef HF_SEQ_OUT_READY_EN
    logic [3:0] rdy_pat;
    int         rdy_idx;
    rdy_pat = 4'b1001;
    rdy_idx = 0;
`endif
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
`ifdef HF_SEQ_OUT_READY_EN
      out_ready = rdy_pat[rdy_idx % 4];
      rdy_idx++;
`endif
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("out_unexpected", out_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("s%0d_sym", e.sym), out_sym, e.sym);
          chk($sformatf("s%0d_code", e.sym), out_code, e.code);
          chk($sformatf("s%0d_len", e.sym), out_len, e.len);
        end
      end
    end
  end

  initial begin
    int lat;
    int low;
    int n;
    int guard;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_freq   = 5'd31;
    in_valid2 = 1'b0;
    in_freq2  = '0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sym", out_sym, 0);
    chk("rst_out_code", out_code, 0);
    chk("rst_out_len", out_len, 0);

    // SYM_NUM=2, freqs 7,3
    in_valid2 = 1'b1;
    in_freq2  = 5'd7;
    @(negedge clk);
    in_freq2 = 5'd3;
    @(negedge clk);
    in_valid2 = 1'b0;
    lat = 1;
    while (!out_valid2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("n2_latency", lat, 2);
    chk("n2_s0_sym", out_sym2, 0);
    chk("n2_s0_code", out_code2, 1);
    chk("n2_s0_len", out_len2, 1);
    @(negedge clk);
    chk("n2_s1_sym", out_sym2, 1);
    chk("n2_s1_code", out_code2, 0);
    chk("n2_s1_len", out_len2, 1);
    @(negedge clk);
    chk("n2_done_valid", out_valid2, 0);
    chk("n2_done_ready", in_ready2, 1);

    // 1,2,3,4,5 with latency check
    exp_a();
    send_sym(5'd1, 0); send_sym(5'd2, 0); send_sym(5'd3, 0); send_sym(5'd4, 0); send_sym(5'd5, 0);
    chk("a_ready_merge", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("a_latency", lat, 5);
    wait_idle();

    // tie chain 1,1,2,4,8 reaches full depth
    exp_sym(0, 'b1110, 4); exp_sym(1, 'b1111, 4); exp_sym(2, 'b110, 3);
    exp_sym(3, 'b10, 2);   exp_sym(4, 'b0, 1);
    send_sym(5'd1, 0); send_sym(5'd1, 0); send_sym(5'd2, 0); send_sym(5'd4, 0); send_sym(5'd8, 0);
    wait_idle();

    // 4,4,4,4,4 then 0,0,0,0,0 with in_valid held high throughout
    exp_flat();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_freq  = 5'd4;
      @(negedge clk);
    end
    exp_flat();
    n     = 0;
    low   = 0;
    guard = 0;
    while (n < 5 && guard < 100) begin
      in_valid = 1'b1;
      if (in_ready) begin
        in_freq = 5'd0;
        n++;
      end else begin
        in_freq = 5'd31;
        low++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    chk("bb_loaded", n, 5);
`ifdef HF_SEQ_OUT_READY_EN
    chk("bb_ready_low", (low >= 9) ? 1 : 0, 1);
`else
    chk("bb_ready_low", low, 9);
`endif
    wait_idle();

    // gapped load, reset in the 2nd merge cycle
    send_sym(5'd1, 2); send_sym(5'd2, 2); send_sym(5'd3, 2); send_sym(5'd4, 2); send_sym(5'd5, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_sym", out_sym, 0);
    chk("mrst_out_code", out_code, 0);
    repeat (12) @(negedge clk);
    chk("mrst_quiet", out_valid, 0);

    exp_a();
    send_sym(5'd1, 2); send_sym(5'd2, 2); send_sym(5'd3, 2); send_sym(5'd4, 2); send_sym(5'd5, 0);
    wait_idle();

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
